// File: rtl/debouncer.sv
// Switch debouncer: 2-flop synchronizer feeding a four-state qualification FSM.
// A level change is accepted after STABLE_CYCLES consecutive synchronized samples.
module debouncer #(
    parameter int unsigned STABLE_CYCLES = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic sw,
    output logic db_level,
    output logic db_tick
);

    localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CntLast = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] CntOne  = CW'(1);

    typedef enum logic [1:0] {
        ZERO,
        WAIT1,
        ONE,
        WAIT0
    } state_e;

    logic          s1;
    logic          s2;
    state_e        state;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1       <= 1'b0;
            s2       <= 1'b0;
            state    <= ZERO;
            cnt      <= '0;
            db_level <= 1'b0;
            db_tick  <= 1'b0;
        end else begin
            s1      <= sw;
            s2      <= s1;
            db_tick <= 1'b0;
            unique case (state)
                ZERO: begin
                    if (s2) begin
                        state <= WAIT1;
                        cnt   <= CntOne;
                    end else begin
                        cnt <= '0;
                    end
                end
                WAIT1: begin
                    if (!s2) begin
                        state <= ZERO;
                        cnt   <= '0;
                    end else if (cnt == CntLast) begin
                        state    <= ONE;
                        cnt      <= '0;
                        db_level <= 1'b1;
                        db_tick  <= 1'b1;
                    end else begin
                        cnt <= cnt + CntOne;
                    end
                end
                ONE: begin
                    if (!s2) begin
                        state <= WAIT0;
                        cnt   <= CntOne;
                    end else begin
                        cnt <= '0;
                    end
                end
                WAIT0: begin
                    // An aborted release returns to ONE silently: level never dropped.
                    if (s2) begin
                        state <= ONE;
                        cnt   <= '0;
                    end else if (cnt == CntLast) begin
                        state    <= ZERO;
                        cnt      <= '0;
                        db_level <= 1'b0;
                    end else begin
                        cnt <= cnt + CntOne;
                    end
                end
                default: begin
                    state    <= ZERO;
                    cnt      <= '0;
                    db_level <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_debouncer.sv
// Bench for debouncer: directed scenarios plus random bouncing input, all checked
// against a sample-history reference model.
module tb_debouncer;

    localparam int unsigned N = 4;

    logic clk = 1'b0;
    logic rst;
    logic sw;
    logic db_level;
    logic db_tick;

    always #5 clk = ~clk;

    debouncer #(.STABLE_CYCLES(N)) dut (
        .clk     (clk),
        .rst     (rst),
        .sw      (sw),
        .db_level(db_level),
        .db_tick (db_tick)
    );

    int   checks = 0;
    int   errors = 0;
    int   ticks  = 0;
    int   e;
    logic prev_tick = 1'b0;

    // Reference: sw delayed two clocks, then the level flips once the last N
    // delayed samples all disagree with the current level.
    logic m_s1, m_s2, m_level, m_tick;
    logic hist[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model(input logic r, input logic s);
        logic agree;
        if (!r) begin
            m_s1    = 1'b0;
            m_s2    = 1'b0;
            m_level = 1'b0;
            m_tick  = 1'b0;
            hist.delete();
        end else begin
            hist.push_back(m_s2);
            if (hist.size() > N) void'(hist.pop_front());
            m_s2   = m_s1;
            m_s1   = s;
            m_tick = 1'b0;
            if (hist.size() == N) begin
                agree = 1'b1;
                foreach (hist[i]) if (hist[i] == m_level) agree = 1'b0;
                if (agree) begin
                    m_level = !m_level;
                    m_tick  = m_level;
                end
            end
        end
    endtask

    task automatic step(input logic r, input logic s);
        rst = r;
        sw  = s;
        @(posedge clk);
        model(r, s);
        #1;
        check("db_level", db_level, m_level);
        check("db_tick", db_tick, m_tick);
        if (prev_tick) check("tick_consecutive", db_tick, 0);
        prev_tick = db_tick;
        if (db_tick === 1'b1) ticks++;
    endtask

    task automatic run_until(input logic target, input logic s, output int edges);
        edges = 0;
        for (int i = 0; i < 40; i++) begin
            step(1'b1, s);
            edges++;
            if (db_level === target) break;
        end
        if (db_level !== target) check("settle_timeout", db_level, target);
    endtask

    initial begin
        // Reset with sw high, then full latency from release.
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        check("rst_level", db_level, 0);
        check("rst_tick", db_tick, 0);
        ticks = 0;
        run_until(1'b1, 1'b1, e);
        check("rst_latency", e, 6);
        check("rst_tick_rise", db_tick, 1);
        step(1'b1, 1'b1);
        check("rst_tick_once", db_tick, 0);

        // Clean press.
        repeat (12) step(1'b1, 1'b0);
        check("low_before_press", db_level, 0);
        ticks = 0;
        run_until(1'b1, 1'b1, e);
        check("press_latency", e, 6);
        check("press_tick", db_tick, 1);
        repeat (18) step(1'b1, 1'b1);
        check("press_ticks", ticks, 1);

        // Glitch rejection.
        repeat (12) step(1'b1, 1'b0);
        ticks = 0;
        repeat (3) step(1'b1, 1'b1);
        repeat (20) step(1'b1, 1'b0);
        check("glitch_ticks", ticks, 0);
        check("glitch_level", db_level, 0);

        // Bounce then hold.
        ticks = 0;
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        run_until(1'b1, 1'b1, e);
        check("bounce_latency", e, 6);
        repeat (10) step(1'b1, 1'b1);
        check("bounce_ticks", ticks, 1);

        // Release, then aborted release.
        ticks = 0;
        run_until(1'b0, 1'b0, e);
        check("release_latency", e, 6);
        check("release_ticks", ticks, 0);
        run_until(1'b1, 1'b1, e);
        ticks = 0;
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        repeat (20) step(1'b1, 1'b1);
        check("abort_release_level", db_level, 1);
        check("abort_release_ticks", ticks, 0);

        // Reset in the middle of qualification.
        repeat (12) step(1'b1, 1'b0);
        ticks = 0;
        repeat (4) step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        check("midrst_level", db_level, 0);
        check("midrst_tick", db_tick, 0);
        run_until(1'b1, 1'b1, e);
        check("midrst_latency", e, 6);
        check("midrst_ticks", ticks, 1);

        // Random bouncing runs with occasional reset.
        for (int k = 0; k < 400; k++) begin
            logic lvl;
            int   len;
            lvl = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 9);
            for (int j = 0; j < len; j++)
                step(($urandom_range(0, 79) != 0), lvl);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/debouncer.md
DEBOUNCER -- requirements
Module: debouncer

Interface
REQ-001 Parameter STABLE_CYCLES, default 20: consecutive synchronized samples needed to accept a level change; legal range 2..65535.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous, active-low (asserted when 0, sampled on rising clk).
REQ-004 sw  input  1  raw, asynchronous, bouncing switch/button level.
REQ-005 db_level  output  1  debounced level; feeds edge_detector sig input.
REQ-006 db_tick  output  1  one-cycle pulse on each accepted 0->1 transition of db_level.

Function
REQ-007 sw SHALL pass through a 2-flop synchronizer (s1, s2) before any use; FSM SHALL sample only s2.
REQ-008 FSM SHALL have exactly four states: ZERO, WAIT1, ONE, WAIT0.
REQ-009 Counter cnt SHALL be $clog2(STABLE_CYCLES+1) bits wide, unsigned; it SHALL never wrap.
REQ-010 ZERO: s2=1 -> WAIT1 with cnt<=1; s2=0 -> stay, cnt<=0.
REQ-011 WAIT1: s2=0 -> ZERO, cnt<=0; s2=1 and cnt==STABLE_CYCLES-1 -> ONE; s2=1 otherwise -> cnt<=cnt+1, stay.
REQ-012 ONE: s2=0 -> WAIT0 with cnt<=1; s2=1 -> stay, cnt<=0.
REQ-013 WAIT0: s2=1 -> ONE, cnt<=0; s2=0 and cnt==STABLE_CYCLES-1 -> ZERO; s2=0 otherwise -> cnt<=cnt+1, stay.
REQ-014 db_level SHALL be registered: 1 in ONE and WAIT0, 0 in ZERO and WAIT1.
REQ-015 db_tick SHALL be registered and equal 1 only in the single cycle immediately after the WAIT1->ONE transition, coinciding with the first cycle of db_level=1.
REQ-016 No db_tick on falling transitions or on WAIT0->ONE (aborted release).
REQ-017 Latency: sw stable high sampled first at edge E0 (held thereafter) -> db_level=1 and db_tick=1 after edge E(STABLE_CYCLES+1); symmetric for release (db_level=0).
REQ-018 Any opposite sample in WAIT1/WAIT0 SHALL abort qualification and restart counting from scratch on the next qualifying sample.
REQ-019 A pulse of sw shorter than STABLE_CYCLES clock periods (after synchronization) SHALL produce no change on db_level and no db_tick.
REQ-020 Two accepted rising transitions SHALL be separated by at least 2*STABLE_CYCLES cycles; db_tick SHALL never be high in two consecutive cycles.

Reset
REQ-021 While rst=0 at a rising edge: s1, s2, cnt <= 0; state <= ZERO; db_level, db_tick <= 0.
REQ-022 Reset SHALL override all other behaviour, including mid-WAIT1/WAIT0 and in ONE; no db_tick is emitted on or after reset release unless a fresh full qualification completes.
REQ-023 After rst returns to 1 with sw held high, acceptance SHALL require the full REQ-017 latency counted from the first post-reset edge.

Verification (STABLE_CYCLES=4, clk period 10)
REQ-024 Reset: rst=0 for 2 cycles, sw=1 -> db_level=0, db_tick=0 throughout reset; db_level=1 and db_tick=1 for one cycle after the 6th edge following release (edges E0..E5).
REQ-025 Clean press: sw 0->1 before E0, held 20 cycles -> db_level=1 after E5, db_tick=1 exactly in cycle after E5, 0 in cycles after E4 and E6.
REQ-026 Glitch reject: sw=1 for 3 cycles then 0 -> db_level and db_tick remain 0 for 20 cycles.
REQ-027 Bounce: sw 1 (2 cycles), 0 (1 cycle), 1 (held) -> exactly one db_tick, db_level rises after 6th edge from final 0->1 sample.
REQ-028 Release: db_level=1, sw 1->0 held -> db_level=0 after 6th edge, db_tick stays 0; sw low for 2 cycles then back high -> db_level stays 1, no db_tick.
REQ-029 Reset mid-WAIT1: rst=0 at third qualifying edge -> outputs 0, state ZERO; with sw still 1, db_tick occurs only after full 6-edge latency post-release.
